// File: rtl/conv3x3_window_ctrl_pkg.sv
// Shared types and constants for the 3x3 convolution window controller.
// Tap indices follow 3*dy+dx with the top-left tap at 0.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int NUM_TAPS = 9;
    localparam int TAP_TL = 0;
    localparam int TAP_T  = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_L  = 3;
    localparam int TAP_C  = 4;
    localparam int TAP_R  = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_B  = 7;
    localparam int TAP_BR = 8;

    // Two full rows plus three pixels cover every tap of a 3x3 window.
    function automatic int delay_depth(input int img_w);
        return 2 * img_w + 3;
    endfunction

endpackage

// File: rtl/conv3x3_window_ctrl_if.sv
// Pixel-stream input, window taps to the datapath and latency-aligned tags.
// The controller uses the slave modport; the pixel source uses master.
interface conv3x3_window_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_sof;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic signed [DATA_WIDTH-1:0] win_data [9];
    logic                         win_valid;
    logic                         out_valid;
    logic                         out_sof;
    logic                         out_eol;
    logic                         out_eof;
    logic                         sync_err;

    modport master (
        output in_valid, in_sof, in_data,
        input  in_ready, win_data, win_valid, out_valid, out_sof, out_eol, out_eof, sync_err
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output in_ready, win_data, win_valid, out_valid, out_sof, out_eol, out_eof, sync_err
    );
endinterface

// File: rtl/conv3x3_window_ctrl_line_delay.sv
// Two-row-plus-three pixel shift register; position 0 holds the newest pixel.
// Taps are presented in window order, so the centre sits IMG_W+1 pixels back.
module line_delay
    import conv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic signed [DATA_WIDTH-1:0] taps [NUM_TAPS]
);
    localparam int DEPTH = delay_depth(IMG_W);

    logic signed [DATA_WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (en) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign taps[TAP_BR] = sr[0];
    assign taps[TAP_B]  = sr[1];
    assign taps[TAP_BL] = sr[2];
    assign taps[TAP_R]  = sr[IMG_W];
    assign taps[TAP_C]  = sr[IMG_W+1];
    assign taps[TAP_L]  = sr[IMG_W+2];
    assign taps[TAP_TR] = sr[2*IMG_W];
    assign taps[TAP_T]  = sr[2*IMG_W+1];
    assign taps[TAP_TL] = sr[2*IMG_W+2];

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Builds zero-padded 3x3 windows from a raster pixel stream and tags datapath results.
//   state | meaning
//   IDLE  | waiting for a start-of-frame pixel, other pixels dropped
//   FILL  | first IMG_W+1 pixels shifted in, no windows yet
//   RUN   | each accepted pixel issues one window
//   FLUSH | input stalled, IMG_W+1 virtual zeros issue the trailing windows
module conv3x3_window_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMG_W        = 32,
    parameter int IMG_H        = 24,
    parameter int CONV_LATENCY = 4
) (
    input  logic clk,
    input  logic reset_n,
    conv3x3_window_ctrl_if.slave bus
);
    localparam int NUM_PIX = IMG_W * IMG_H;
    localparam int PW      = $clog2(NUM_PIX + 1);
    localparam int CW      = $clog2(IMG_W + 1);
    localparam int RW      = $clog2(IMG_H + 1);

    state_t                       state, state_nx;
    logic                         ready_q, xfer;
    logic                         shift_en, win_step, frame_start, sync_hit, flush_done;
    logic signed [DATA_WIDTH-1:0] shift_din;
    logic signed [DATA_WIDTH-1:0] taps [NUM_TAPS];
    logic [PW-1:0]                pix_cnt;
    logic [CW-1:0]                col, flush_cnt;
    logic [RW-1:0]                row;
    logic                         col_last, row_last, first_win;
    logic [NUM_TAPS-1:0]          mask_nx, mask_q;
    logic                         win_valid_q, win_sof_q, win_eol_q, win_eof_q, sync_err_q;
    logic [3:0]                   tag_pipe [CONV_LATENCY];

    assign xfer     = bus.in_valid & ready_q;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));

    line_delay #(.DATA_WIDTH(DATA_WIDTH), .IMG_W(IMG_W)) u_line_delay (
        .clk   (clk),
        .clr_n (reset_n),
        .en    (shift_en),
        .din   (shift_din),
        .taps  (taps)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        shift_en    = 1'b0;
        shift_din   = bus.in_data;
        win_step    = 1'b0;
        frame_start = 1'b0;
        sync_hit    = 1'b0;
        flush_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer && bus.in_sof) begin
                    shift_en    = 1'b1;
                    frame_start = 1'b1;
                    state_nx    = FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    shift_en = 1'b1;
                    if (bus.in_sof) begin
                        frame_start = 1'b1;
                        sync_hit    = 1'b1;
                    end else if (pix_cnt == PW'(IMG_W)) begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    shift_en = 1'b1;
                    if (bus.in_sof) begin
                        frame_start = 1'b1;
                        sync_hit    = 1'b1;
                        state_nx    = FILL;
                    end else begin
                        win_step = 1'b1;
                        if (pix_cnt == PW'(NUM_PIX - 1)) state_nx = FLUSH;
                    end
                end
            end
            FLUSH: begin
                shift_en  = 1'b1;
                shift_din = '0;
                win_step  = 1'b1;
                if (flush_cnt == '0) begin
                    state_nx   = IDLE;
                    flush_done = 1'b1;
                end
            end
        endcase
    end

    // Padding: taps outside the image, including column-wrap pixels, are zeroed.
    always_comb begin
        mask_nx = '1;
        for (int t = 0; t < NUM_TAPS; t++) begin
            if ((t < 3 && row == '0) || (t >= 6 && row_last) ||
                (t % 3 == 0 && col == '0) || (t % 3 == 2 && col_last))
                mask_nx[t] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            pix_cnt     <= '0;
            flush_cnt   <= '0;
            col         <= '0;
            row         <= '0;
            first_win   <= 1'b0;
            mask_q      <= '0;
            win_valid_q <= 1'b0;
            win_sof_q   <= 1'b0;
            win_eol_q   <= 1'b0;
            win_eof_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            ready_q <= (state_nx != FLUSH);

            if (frame_start)                      pix_cnt <= PW'(1);
            else if (shift_en && state != FLUSH)  pix_cnt <= pix_cnt + 1'b1;

            if (state != FLUSH && state_nx == FLUSH) flush_cnt <= CW'(IMG_W);
            else if (state == FLUSH)                 flush_cnt <= flush_cnt - 1'b1;

            if (frame_start) begin
                col <= '0;
                row <= '0;
            end else if (win_step) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (frame_start)   first_win <= 1'b1;
            else if (win_step) first_win <= 1'b0;

            if (win_step)      mask_q <= mask_nx;
            else if (shift_en) mask_q <= '0;

            win_valid_q <= win_step;
            win_sof_q   <= win_step & first_win;
            win_eol_q   <= win_step & col_last;
            win_eof_q   <= win_step & col_last & row_last;

            if (sync_hit)        sync_err_q <= 1'b1;
            else if (flush_done) sync_err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CONV_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= {win_valid_q, win_sof_q, win_eol_q, win_eof_q};
            for (int i = 1; i < CONV_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_TAPS; t++)
            bus.win_data[t] = mask_q[t] ? taps[t] : '0;
    end

    assign bus.in_ready  = ready_q;
    assign bus.win_valid = win_valid_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.out_valid = tag_pipe[CONV_LATENCY-1][3];
    assign bus.out_sof   = tag_pipe[CONV_LATENCY-1][2];
    assign bus.out_eol   = tag_pipe[CONV_LATENCY-1][1];
    assign bus.out_eof   = tag_pipe[CONV_LATENCY-1][0];

endmodule

// File: tb/tb_conv3x3_window_ctrl.sv
// Bench for conv3x3_window_ctrl on a 4x3 image: directed scenarios with random pixels,
// checked against a window/tag model computed directly from image coordinates.
module tb_conv3x3_window_ctrl;
    localparam int W   = 4;
    localparam int H   = 3;
    localparam int N   = W * H;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    conv3x3_window_ctrl_if #(.DATA_WIDTH(8)) bus ();

    conv3x3_window_ctrl #(
        .DATA_WIDTH(8), .IMG_W(W), .IMG_H(H), .CONV_LATENCY(LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int win_cyc_q[$];
    logic [71:0] win_dat_q[$];
    int out_cyc_q[$];
    logic [2:0] out_tag_q[$];
    int xfer_q[$];
    int pix [2][N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [71:0] p;
        if (bus.win_valid) begin
            for (int t = 0; t < 9; t++) p[t*8 +: 8] = bus.win_data[t];
            win_cyc_q.push_back(cyc);
            win_dat_q.push_back(p);
        end
        if (bus.out_valid) begin
            out_cyc_q.push_back(cyc);
            out_tag_q.push_back({bus.out_sof, bus.out_eol, bus.out_eof});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_tap(input int f, input int ctr, input int t);
        int r, c;
        r = ctr / W + t / 3 - 1;
        c = ctr % W + t % 3 - 1;
        if (r < 0 || r >= H || c < 0 || c >= W) return 8'h00;
        return 8'(pix[f][r*W + c]);
    endfunction

    task automatic clear_q();
        win_cyc_q.delete(); win_dat_q.delete();
        out_cyc_q.delete(); out_tag_q.delete();
        xfer_q.delete();
    endtask

    task automatic push(input logic [7:0] d, input logic s, output int waited);
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = s;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            chk("ready_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        xfer_q.push_back(cyc);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int f, input bit gap);
        int w;
        for (int i = 0; i < N; i++) begin
            push(8'(pix[f][i]), (i == 0), w);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic randomize_frame(input int f);
        for (int i = 0; i < N; i++) pix[f][i] = int'($urandom_range(0, 255));
    endtask

    // Window i of a frame is centred at raster index i; it issues with the transfer of
    // pixel i+W+1, or for the last W+1 centres on consecutive cycles after the last pixel.
    task automatic check_frame(input int woff, input int xoff, input int f, input string nm, input int total);
        int ew;
        logic [71:0] wd;
        chk({nm, "_win_count"}, win_cyc_q.size(), total);
        chk({nm, "_out_count"}, out_cyc_q.size(), total);
        if (win_cyc_q.size() != total || out_cyc_q.size() != total || xfer_q.size() < xoff + N) return;
        for (int i = 0; i < N; i++) begin
            ew = (i < N - W - 1) ? xfer_q[xoff + i + W + 1] : xfer_q[xoff + N - 1] + 1 + i - (N - W - 1);
            chk($sformatf("%s_win_cyc[%0d]", nm, i), win_cyc_q[woff + i], ew);
            wd = win_dat_q[woff + i];
            for (int t = 0; t < 9; t++)
                chk($sformatf("%s_tap[%0d][%0d]", nm, i, t), wd[t*8 +: 8], ref_tap(f, i, t));
            chk($sformatf("%s_out_cyc[%0d]", nm, i), out_cyc_q[woff + i], ew + LAT);
            chk($sformatf("%s_tags[%0d]", nm, i), out_tag_q[woff + i],
                {(i == 0), (i % W == W - 1), (i == N - 1)});
        end
    endtask

    task automatic chk_win_lit(input string nm, input int idx, input int v[9]);
        logic [71:0] wd;
        if (win_dat_q.size() <= idx) begin
            chk({nm, "_present"}, win_dat_q.size(), idx + 1);
            return;
        end
        wd = win_dat_q[idx];
        for (int t = 0; t < 9; t++) chk($sformatf("%s[%0d]", nm, t), wd[t*8 +: 8], 8'(v[t]));
    endtask

    initial begin
        int w, cnt, nsof, neof;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_win_valid", bus.win_valid, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sync_err", bus.sync_err, 0);
        chk("rst_win_data_c", bus.win_data[4], 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.in_ready, 1);

        // A pixel without sof in IDLE is dropped
        push(8'd77, 1'b0, w);
        repeat (10) @(negedge clk);
        chk("idle_drop_wins", win_cyc_q.size(), 0);
        clear_q();

        // Frame of 1..12 back-to-back
        for (int i = 0; i < N; i++) pix[0][i] = i + 1;
        send_frame(0, 1'b0);
        cnt = 0;
        while (!bus.in_ready && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("flush_ready_low", cnt, W + 1);
        repeat (20) @(negedge clk);
        check_frame(0, 0, 0, "seq", N);
        chk_win_lit("first_win", 0, '{0, 0, 0, 0, 1, 2, 0, 5, 6});
        chk_win_lit("r1c3_win", 7, '{3, 4, 0, 7, 8, 0, 11, 12, 0});
        chk_win_lit("r1c0_win", 4, '{0, 1, 2, 0, 5, 6, 0, 9, 10});
        chk("seq_sync_err", bus.sync_err, 0);

        // Same frame with in_valid toggling
        clear_q();
        send_frame(0, 1'b1);
        repeat (20) @(negedge clk);
        check_frame(0, 0, 0, "gap", N);

        // Resync: sof re-asserted on the 7th pixel
        clear_q();
        randomize_frame(1);
        for (int i = 0; i < 6; i++) push(8'(pix[1][i]), (i == 0), w);
        randomize_frame(0);
        push(8'(pix[0][0]), 1'b1, w);
        chk("resync_sync_err_set", bus.sync_err, 1);
        for (int i = 1; i < N; i++) push(8'(pix[0][i]), 1'b0, w);
        repeat (20) @(negedge clk);
        check_frame(1, 6, 0, "resync", N + 1);
        if (out_tag_q.size() > 0) chk("resync_partial_sof", out_tag_q[0], 3'b100);
        chk("resync_sync_err_clr", bus.sync_err, 0);

        // Reset asserted at pixel 8
        clear_q();
        randomize_frame(0);
        for (int i = 0; i < 7; i++) push(8'(pix[0][i]), (i == 0), w);
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_win_valid", bus.win_valid, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_win_data_c", bus.win_data[4], 0);
        chk("midrst_win_data_br", bus.win_data[8], 0);
        clear_q();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_out", out_cyc_q.size(), 0);
        chk("midrst_no_win", win_cyc_q.size(), 0);
        randomize_frame(0);
        send_frame(0, 1'b0);
        repeat (20) @(negedge clk);
        check_frame(0, 0, 0, "postrst", N);

        // Two frames back-to-back
        clear_q();
        randomize_frame(0);
        randomize_frame(1);
        send_frame(0, 1'b0);
        push(8'(pix[1][0]), 1'b1, w);
        chk("b2b_sof_wait", w, W + 1);
        for (int i = 1; i < N; i++) push(8'(pix[1][i]), 1'b0, w);
        repeat (20) @(negedge clk);
        check_frame(0, 0, 0, "b2b_a", 2 * N);
        check_frame(N, N, 1, "b2b_b", 2 * N);
        nsof = 0;
        neof = 0;
        foreach (out_tag_q[i]) begin
            nsof += int'(out_tag_q[i][2]);
            neof += int'(out_tag_q[i][0]);
        end
        chk("b2b_sof_count", nsof, 2);
        chk("b2b_eof_count", neof, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv3x3_window_ctrl.md
Name: conv3x3_window_ctrl

Overview:
- Sequences the shared 3x3 convolution datapath (9-tap multiply plus 4-stage adder tree) for one feature-map channel.
- Accepts a raster-order pixel stream and builds 3x3 windows with zero padding ("same" output size), issuing one window per cycle to the datapath.
- Tracks the datapath's fixed pipeline latency and emits valid/position tags aligned with the datapath result, so downstream stages need no latency knowledge.

Parameters:
- DATA_WIDTH, 8, pixel width (signed)
- IMG_W, 32, image width in pixels (>=3)
- IMG_H, 24, image height in pixels (>=2)
- CONV_LATENCY, 4, register stages between window presentation and datapath result

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts a pixel (in_valid & in_ready = transfer)
- in_sof  in  1  marks the first pixel of a frame; qualified by transfer
- in_data  in  DATA_WIDTH  signed pixel
- win_data[9]  out  DATA_WIDTH each  window taps to the datapath; index = 3*dy+dx, top-left = 0, centre = 4
- win_valid  out  1  win_data holds a real window this cycle
- out_valid  out  1  datapath output valid this cycle (win_valid delayed by CONV_LATENCY)
- out_sof  out  1  first output of frame, aligned with out_valid
- out_eol  out  1  last output of a row, aligned
- out_eof  out  1  last output of frame, aligned
- sync_err  out  1  sticky; in_sof seen mid-frame; cleared by reset or next frame completion

Behaviour:
- Reset: in_ready=0 while reset_n low, 1 on first cycle after; all other outputs 0; win_data all 0; shift register contents 0; FSM=IDLE.
- Window generation: input raster index k produces a window centred at index k-(IMG_W+1) (lag IMG_W+1). Taps come from a delay line of 2*IMG_W+3 entries, shifted on each transfer or flush step.
- Padding: taps with row<0, row>=IMG_H, col<0 or col>=IMG_W (relative to the centre's row/col counters) are forced to 0. Column wrap pixels sitting in the delay line are masked, never passed through.
- FSM states:
  - IDLE: in_ready=1; a transfer with in_sof=1 -> FILL. Transfers without in_sof are dropped.
  - FILL: the first IMG_W+1 pixels (including the sof pixel) are shifted in with win_valid=0, then -> RUN.
  - RUN: each transfer shifts in the pixel and asserts win_valid the next cycle. When the pixel at index IMG_W*IMG_H-1 transfers -> FLUSH.
  - FLUSH: in_ready=0. IMG_W+1 consecutive cycles each shift in a virtual 0 and assert win_valid, then -> IDLE.
- Window outputs: win_data and win_valid are registered, 1 cycle after the causing transfer or flush step. In-frame gaps in in_valid produce gaps in win_valid; the delay line holds its contents.
- Counters: centre col 0..IMG_W-1 and row 0..IMG_H-1 advance on each issued window. col wraps to 0 at IMG_W-1 and increments row.
- Tags: eol = centre col==IMG_W-1; eof = eol & row==IMG_H-1; sof = first window. Tags and win_valid pass through a CONV_LATENCY-deep shift register to form out_*. Exactly IMG_W*IMG_H out_valid pulses per frame.
- in_sof while in FILL or RUN: set sync_err, discard the partial frame, clear counters, treat the pixel as the new frame's first pixel (-> FILL). Windows already in the latency pipe still emerge unchanged.
- Frame completion: if the next frame's sof pixel is offered during FLUSH it waits (in_ready=0) and is accepted from IDLE. Minimum gap is IMG_W+1 cycles plus 1 IDLE cycle.
- Reset mid-frame: all state is discarded immediately and pending out_valid pulses are lost.
- No output backpressure; the datapath never stalls.

Decomposition:
- Package conv_ctrl_pkg: FSM state enum (IDLE, FILL, RUN, FLUSH), tap index constants (TAP_TL=0 … TAP_BR=8, TAP_C=4), and a function computing delay-line depth from IMG_W.
- One sub-module: line_delay. A parameterised DATA_WIDTH x DEPTH shift register with enable and asynchronous active-low clear, exposing taps 0, 1, 2, IMG_W, IMG_W+1, IMG_W+2, 2*IMG_W, 2*IMG_W+1 and 2*IMG_W+2.
- The controller instantiates line_delay, the FSM, the counters and the tag delay pipe.

Test Plan:
- IMG_W=4, IMG_H=3, pixels 1..12 back-to-back with sof on pixel 1. Expect:
  - win_valid first high 1 cycle after pixel 6 transfers.
  - First window = {0,0,0, 0,1,2, 0,5,6}.
  - 12 windows total; the last 5 come during FLUSH with in_ready=0.
  - out_valid trails win_valid by exactly 4 cycles; out_eol on outputs 4, 8, 12; out_eof on output 12 only.
- Same frame with in_valid toggling 1/0 every cycle. Expect identical window contents and order, win_valid gaps matching the input gaps, same tag positions.
- Column masking: centre (row 1, col 3) window = {3,4,0, 7,8,0, 11,12,0}. Centre (row 1, col 0) window = {0,1,2, 0,5,6, 0,9,10}.
- Resync: in_sof re-asserted on pixel 7. Expect sync_err=1, no window from the partial frame issued after that point, and a complete correct 12-window frame from the new sof.
- Reset asserted at pixel 8. Expect all outputs 0 asynchronously and no further out_valid; after release, a fresh frame produces 12 correct outputs.
- Two frames offered back-to-back. Expect in_ready low for 5 FLUSH cycles, the second frame's sof accepted in IDLE, and 24 out_valid pulses with 2 out_sof and 2 out_eof.
